// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module      : register_bank
// Description : CPU-style register bank. NUM_GPR general-purpose registers
//               (0 = accumulator, 1 = X, 2 = Y) with write/increment/decrement
//               and N/Z flag generation, a wrapping stack pointer with a
//               one-cycle wrap pulse, and a maskable 8-bit status register.
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank #(
  parameter int               WIDTH      = 8,
  parameter int               NUM_GPR    = 3,
  parameter logic [WIDTH-1:0] SP_RST     = '1,
  parameter logic [7:0]       STATUS_RST = 8'h20,
  parameter int               N_BIT      = 7,
  parameter int               Z_BIT      = 1,
  localparam int              SELW       = (NUM_GPR > 2) ? $clog2(NUM_GPR) : 1
) (
  input  logic             clk_1,
  input  logic             rst,
  input  logic [SELW-1:0]  gpr_sel,
  input  logic             gpr_we,
  input  logic             gpr_inc,
  input  logic             gpr_dec,
  input  logic [WIDTH-1:0] data_in,
  input  logic             nz_en,
  input  logic             sp_load,
  input  logic             sp_push,
  input  logic             sp_pop,
  input  logic             status_we,
  input  logic [7:0]       status_mask,
  input  logic [7:0]       data_status,
  input  logic [SELW-1:0]  rd_sel_a,
  input  logic [SELW-1:0]  rd_sel_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [WIDTH-1:0] data_out_sp,
  output logic [7:0]       data_out_status,
  output logic             sp_wrap
);

  logic [WIDTH-1:0] gpr_q [NUM_GPR];
  logic [WIDTH-1:0] gpr_d [NUM_GPR];
  logic [WIDTH-1:0] sp_q;
  logic [WIDTH-1:0] sp_d;
  logic [7:0]       status_q;
  logic [7:0]       status_d;
  logic             sp_wrap_q;
  logic             sp_wrap_d;

  logic             sel_ok;
  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] gpr_result;
  logic             gpr_any;
  logic             gpr_write;

  // Decode the targeted GPR and form the operation result.
  // inc+dec together leaves the register alone, yet the flag result is then
  // taken from data_in, so the flag path and the write path differ here.
  always_comb begin
    sel_ok  = int'(gpr_sel) < NUM_GPR;
    sel_val = '0;
    for (int i = 0; i < NUM_GPR; i++) begin
      if (gpr_sel == SELW'(i)) sel_val = gpr_q[i];
    end
    gpr_any   = sel_ok & (gpr_we | gpr_inc | gpr_dec);
    gpr_write = sel_ok & (gpr_we | (gpr_inc ^ gpr_dec));
    if (gpr_we || (gpr_inc && gpr_dec)) begin
      gpr_result = data_in;
    end else if (gpr_inc) begin
      gpr_result = sel_val + WIDTH'(1);
    end else begin
      gpr_result = sel_val - WIDTH'(1);
    end
  end

  // Next state of each GPR: only the selected register can change.
  always_comb begin
    for (int i = 0; i < NUM_GPR; i++) begin
      gpr_d[i] = gpr_q[i];
      if (gpr_write && (gpr_sel == SELW'(i))) gpr_d[i] = gpr_result;
    end
  end

  // Stack pointer next state; a load never counts as a wrap.
  always_comb begin
    sp_d      = sp_q;
    sp_wrap_d = 1'b0;
    if (sp_load) begin
      sp_d = data_in;
    end else if (sp_push && !sp_pop) begin
      sp_d      = sp_q - WIDTH'(1);
      sp_wrap_d = (sp_q == '0);
    end else if (sp_pop && !sp_push) begin
      sp_d      = sp_q + WIDTH'(1);
      sp_wrap_d = (sp_q == '1);
    end
  end

  // Status next state: N/Z flag update first, explicit masked write on top.
  always_comb begin
    status_d = status_q;
    if (nz_en && gpr_any) begin
      status_d[N_BIT] = gpr_result[WIDTH-1];
      status_d[Z_BIT] = (gpr_result == '0);
    end
    if (status_we) begin
      status_d = (status_d & ~status_mask) | (data_status & status_mask);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_1) begin
    if (!rst) begin
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      sp_q      <= SP_RST;
      status_q  <= STATUS_RST;
      sp_wrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= gpr_d[i];
      sp_q      <= sp_d;
      status_q  <= status_d;
      sp_wrap_q <= sp_wrap_d;
    end
  end

  // Combinational read ports; out-of-range selects read zero.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    for (int i = 0; i < NUM_GPR; i++) begin
      if (rd_sel_a == SELW'(i)) rd_data_a = gpr_q[i];
      if (rd_sel_b == SELW'(i)) rd_data_b = gpr_q[i];
    end
  end

  assign data_out_sp     = sp_q;
  assign data_out_status = status_q;
  assign sp_wrap         = sp_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_bank
// Description : Scoreboard bench for register_bank: stimulus queues expected
//               values tagged with the cycle they become visible, a monitor
//               pops and compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_bank;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  // Default instance (WIDTH 8, NUM_GPR 3)
  logic [1:0] gpr_sel, rd_sel_a, rd_sel_b;
  logic       gpr_we, gpr_inc, gpr_dec, nz_en, sp_load, sp_push, sp_pop, status_we;
  logic [7:0] data_in, status_mask, data_status;
  logic [7:0] rd_data_a, rd_data_b, data_out_sp, data_out_status;
  logic       sp_wrap;

  // Wide instance (WIDTH 16, NUM_GPR 5)
  logic [2:0]  gpr_sel_w, rd_sel_a_w, rd_sel_b_w;
  logic        gpr_we_w, gpr_inc_w, gpr_dec_w, nz_en_w;
  logic [15:0] data_in_w;
  logic [15:0] rd_data_a_w, rd_data_b_w, data_out_sp_w;
  logic [7:0]  data_out_status_w;
  logic        sp_wrap_w;

  register_bank dut (
    .clk_1(clk), .rst(rst), .gpr_sel(gpr_sel), .gpr_we(gpr_we), .gpr_inc(gpr_inc),
    .gpr_dec(gpr_dec), .data_in(data_in), .nz_en(nz_en), .sp_load(sp_load),
    .sp_push(sp_push), .sp_pop(sp_pop), .status_we(status_we),
    .status_mask(status_mask), .data_status(data_status), .rd_sel_a(rd_sel_a),
    .rd_sel_b(rd_sel_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .data_out_sp(data_out_sp), .data_out_status(data_out_status), .sp_wrap(sp_wrap)
  );

  register_bank #(.WIDTH(16), .NUM_GPR(5)) dut_w (
    .clk_1(clk), .rst(rst), .gpr_sel(gpr_sel_w), .gpr_we(gpr_we_w), .gpr_inc(gpr_inc_w),
    .gpr_dec(gpr_dec_w), .data_in(data_in_w), .nz_en(nz_en_w), .sp_load(1'b0),
    .sp_push(1'b0), .sp_pop(1'b0), .status_we(1'b0),
    .status_mask(8'h00), .data_status(8'h00), .rd_sel_a(rd_sel_a_w),
    .rd_sel_b(rd_sel_b_w), .rd_data_a(rd_data_a_w), .rd_data_b(rd_data_b_w),
    .data_out_sp(data_out_sp_w), .data_out_status(data_out_status_w), .sp_wrap(sp_wrap_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] actual(int k);
    case (k)
      0:       return 32'(rd_data_a);
      1:       return 32'(rd_data_b);
      2:       return 32'(data_out_sp);
      3:       return 32'(data_out_status);
      4:       return 32'(sp_wrap);
      5:       return 32'(rd_data_a_w);
      6:       return 32'(rd_data_b_w);
      7:       return 32'(data_out_status_w);
      8:       return 32'(data_out_sp_w);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; stale ones are failures.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        logic [31:0] act;
        act = actual(sbq[i].kind);
        n_cmp++;
        if (act !== sbq[i].val) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", sbq[i].tag, act, sbq[i].val);
        end
        sbq.delete(i);
      end else if (sbq[i].cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: never sampled, expected 0x%0h", sbq[i].tag, sbq[i].val);
        sbq.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expectation visible after the coming edge
  task automatic expn(int k, logic [31:0] v, string t);
    sbq.push_back('{cyc + 1, k, v, t});
  endtask

  // Expectation on the combinational read path in the current cycle
  task automatic expc(int k, logic [31:0] v, string t);
    sbq.push_back('{cyc, k, v, t});
  endtask

  task automatic idle();
    gpr_we = 0; gpr_inc = 0; gpr_dec = 0; nz_en = 0;
    sp_load = 0; sp_push = 0; sp_pop = 0; status_we = 0;
    status_mask = 8'h00; data_status = 8'h00;
    gpr_we_w = 0; gpr_inc_w = 0; gpr_dec_w = 0; nz_en_w = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] sp_m;
    logic [7:0] sp_nx;

    // Reset with every enable asserted
    rst = 0;
    gpr_we = 1; gpr_inc = 1; gpr_dec = 1; nz_en = 1;
    sp_load = 1; sp_push = 1; sp_pop = 1; status_we = 1;
    status_mask = 8'hFF; data_status = 8'h00; data_in = 8'h55; gpr_sel = 2'd0;
    rd_sel_a = 2'd0; rd_sel_b = 2'd1;
    gpr_sel_w = 3'd0; gpr_we_w = 1; gpr_inc_w = 0; gpr_dec_w = 0; nz_en_w = 1;
    data_in_w = 16'h1234; rd_sel_a_w = 3'd0; rd_sel_b_w = 3'd1;
    expn(0, 32'h00, "rst_gpr0");
    expn(1, 32'h00, "rst_gpr1");
    expn(2, 32'hFF, "rst_sp");
    expn(3, 32'h20, "rst_status");
    expn(4, 32'h0, "rst_wrap");
    expn(7, 32'h20, "rst_status16");
    expn(8, 32'hFFFF, "rst_sp16");
    expn(5, 32'h0000, "rst_gpr0_16");
    tick();

    rst = 1; idle();
    rd_sel_a = 2'd2;
    expc(0, 32'h00, "rst_gpr2");
    gpr_sel = 2'd1; gpr_we = 1; data_in = 8'h80; nz_en = 1;
    expc(1, 32'h00, "no_bypass");
    expn(1, 32'h80, "write_x_80");
    expn(3, 32'hA0, "nz_neg");
    tick();

    idle(); gpr_sel = 2'd1; gpr_we = 1; data_in = 8'h01; nz_en = 1;
    expn(1, 32'h01, "write_x_01");
    expn(3, 32'h20, "nz_pos");
    tick();

    idle(); gpr_sel = 2'd1; gpr_dec = 1; nz_en = 1;
    expn(1, 32'h00, "dec_to_zero");
    expn(3, 32'h22, "nz_zero");
    tick();

    idle(); rd_sel_b = 2'd0; gpr_sel = 2'd0; gpr_we = 1; gpr_inc = 1; data_in = 8'h37;
    expn(1, 32'h37, "we_beats_inc");
    expn(3, 32'h22, "status_hold");
    tick();

    idle(); gpr_sel = 2'd0; gpr_inc = 1; gpr_dec = 1;
    expn(1, 32'h37, "inc_dec_hold");
    tick();

    idle(); rd_sel_a = 2'd2; gpr_sel = 2'd2; gpr_dec = 1; nz_en = 1;
    expn(0, 32'hFF, "dec_wrap");
    expn(3, 32'hA0, "dec_wrap_nz");
    tick();

    idle(); gpr_sel = 2'd2; gpr_inc = 1; nz_en = 1;
    expn(0, 32'h00, "inc_wrap");
    expn(3, 32'h22, "inc_wrap_nz");
    tick();

    idle(); rd_sel_a = 2'd3; gpr_sel = 2'd3; gpr_we = 1; data_in = 8'hAA; nz_en = 1;
    expc(0, 32'h00, "rd_sel_oob");
    expn(1, 32'h37, "sel_oob_ignored");
    expn(3, 32'h22, "sel_oob_no_nz");
    tick();

    idle(); rd_sel_a = 2'd1; gpr_sel = 2'd1; gpr_we = 1; data_in = 8'hFF;
    expn(0, 32'hFF, "load_x_ff");
    tick();

    idle(); gpr_sel = 2'd1; gpr_inc = 1; nz_en = 1;
    status_we = 1; status_mask = 8'h02; data_status = 8'h00;
    expn(0, 32'h00, "mask_inc");
    expn(3, 32'h20, "mask_precedence");
    tick();

    idle(); status_we = 1; status_mask = 8'hF0; data_status = 8'h5A;
    expn(3, 32'h50, "masked_write");
    tick();

    idle(); sp_push = 1; sp_pop = 1;
    expn(2, 32'hFF, "push_pop_hold");
    expn(4, 32'h0, "push_pop_no_wrap");
    tick();

    idle(); sp_load = 1; sp_push = 1; data_in = 8'h10;
    expn(2, 32'h10, "load_beats_push");
    expn(4, 32'h0, "load_no_wrap");
    tick();

    idle(); sp_load = 1; data_in = 8'hFF;
    expn(2, 32'hFF, "load_ff");
    expn(4, 32'h0, "load_ff_no_wrap");
    tick();

    // 256 pushes: one full lap, single wrap at 00 -> FF
    sp_m = 8'hFF;
    for (int n = 0; n < 256; n++) begin
      idle(); sp_push = 1;
      sp_nx = sp_m - 8'h01;
      expn(2, 32'(sp_nx), "push_lap_sp");
      expn(4, (sp_m == 8'h00) ? 32'h1 : 32'h0, "push_lap_wrap");
      sp_m = sp_nx;
      tick();
    end

    idle(); sp_pop = 1;
    expn(2, 32'h00, "pop_wrap_sp");
    expn(4, 32'h1, "pop_wrap_pulse");
    tick();

    idle();
    expn(2, 32'h00, "sp_hold");
    expn(4, 32'h0, "wrap_one_cycle");
    tick();

    // Reset while pushing at SP = 0: no wrap pulse
    idle(); sp_push = 1; rst = 0; rd_sel_a = 2'd0;
    expn(2, 32'hFF, "rst_mid_push_sp");
    expn(4, 32'h0, "rst_mid_push_wrap");
    expn(3, 32'h20, "rst2_status");
    expn(0, 32'h00, "rst2_acc");
    tick();

    // All three paths in one cycle
    rst = 1; idle();
    gpr_sel = 2'd0; gpr_we = 1; data_in = 8'h80; nz_en = 1; sp_push = 1;
    status_we = 1; status_mask = 8'h01; data_status = 8'h01;
    expn(0, 32'h80, "concurrent_gpr");
    expn(2, 32'hFE, "concurrent_sp");
    expn(3, 32'hA1, "concurrent_status");
    expn(4, 32'h0, "concurrent_wrap");
    tick();

    // Wide instance
    idle(); gpr_sel_w = 3'd4; gpr_we_w = 1; data_in_w = 16'hFFFF; rd_sel_a_w = 3'd4;
    expn(5, 32'hFFFF, "w16_load");
    tick();

    idle(); gpr_sel_w = 3'd4; gpr_inc_w = 1; nz_en_w = 1;
    expn(5, 32'h0000, "w16_inc_wrap");
    expn(7, 32'h22, "w16_nz_zero");
    tick();

    idle(); gpr_sel_w = 3'd6; gpr_we_w = 1; data_in_w = 16'h8421; nz_en_w = 1;
    rd_sel_a_w = 3'd6; rd_sel_b_w = 3'd7;
    expc(5, 32'h0000, "w16_rd_sel6");
    expc(6, 32'h0000, "w16_rd_sel7");
    expn(7, 32'h22, "w16_sel6_no_nz");
    tick();

    idle(); rd_sel_a_w = 3'd2; rd_sel_b_w = 3'd4;
    expc(5, 32'h0000, "w16_sel6_no_alias");
    expc(6, 32'h0000, "w16_sel6_gpr4");
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH, 8, register width in bits; legal values 8..32.
  NUM_GPR, 3, number of general-purpose registers (index 0 = accumulator, 1 = X, 2 = Y); legal values 2..16.
  SP_RST, all-ones of WIDTH, stack-pointer reset value.
  STATUS_RST, 8'h20, status reset value.
  N_BIT, 7, status bit index of the negative flag.
  Z_BIT, 1, status bit index of the zero flag.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. SELW = max(1, clog2(NUM_GPR)).
  clk_1  in  1  sole clock; all state updates on its rising edge.
  rst  in  1  synchronous, active-low reset.
  gpr_sel  in  SELW  target GPR for the write, increment and decrement operations.
  gpr_we  in  1  load data_in into GPR[gpr_sel].
  gpr_inc  in  1  GPR[gpr_sel] + 1.
  gpr_dec  in  1  GPR[gpr_sel] - 1.
  data_in  in  WIDTH  write data.
  nz_en  in  1  update N and Z from the GPR result.
  sp_load  in  1  load data_in into SP.
  sp_push  in  1  decrement SP.
  sp_pop  in  1  increment SP.
  status_we  in  1  masked status write.
  status_mask  in  8  bits of status written by status_we.
  data_status  in  8  status write data.
  rd_sel_a, rd_sel_b  in  SELW each  read-port selects.
  rd_data_a, rd_data_b  out  WIDTH each  GPR[rd_sel_a], GPR[rd_sel_b].
  data_out_sp  out  WIDTH  stack pointer.
  data_out_status  out  8  status register.
  sp_wrap  out  1  registered one-cycle pulse on a stack-pointer wrap.

Function
REQ-003 Read ports SHALL be combinational from the current register contents, with zero latency; a select value >= NUM_GPR SHALL read 0.
REQ-004 GPR updates SHALL take effect at the clock edge and be visible on the read ports in the following cycle; there is no write-to-read bypass.
REQ-005 GPR operation priority SHALL be: gpr_we over gpr_inc/gpr_dec; gpr_inc and gpr_dec together with no gpr_we SHALL leave the register unchanged.
REQ-006 Increment and decrement SHALL wrap modulo 2^WIDTH (max+1 gives 0; 0-1 gives max) and SHALL NOT set any carry flag.
REQ-007 A gpr_sel value >= NUM_GPR SHALL ignore all GPR operations, including the NZ update.
REQ-008 When nz_en is high and a GPR operation takes effect, N SHALL equal result[WIDTH-1] and Z SHALL equal (result == 0); here result is the value written that cycle, which is data_in when both inc and dec are high.
REQ-009 Status update: bits with status_mask = 1 SHALL take data_status when status_we is high; the N and Z bits SHALL take the NZ update only where their mask bit is 0 or status_we is low; all other bits SHALL hold.
REQ-010 Stack-pointer priority SHALL be: sp_load over push/pop; push and pop together with no load SHALL leave SP unchanged.
REQ-011 A push at SP = 0 SHALL give all-ones, and a pop at SP = all-ones SHALL give 0; each case SHALL assert sp_wrap for exactly the next cycle.
REQ-012 An sp_load of any value SHALL NOT assert sp_wrap; sp_wrap SHALL be 0 in every other cycle.
REQ-013 The GPR, SP and status paths SHALL be independent: all three may update in the same cycle.

Reset
REQ-014 At a clk_1 edge with rst = 0, the block SHALL set all GPRs to 0, SP to SP_RST, status to STATUS_RST and sp_wrap to 0, overriding all other inputs.
REQ-015 rst SHALL have no effect between clock edges; a reset asserted mid-push SHALL yield SP_RST and no sp_wrap pulse.

Verification
REQ-016 Reset: hold rst = 0 for one edge with every enable high -> GPRs 0, SP 8'hFF, status 8'h20, sp_wrap 0.
REQ-017 Write/NZ: gpr_sel = 1, gpr_we, data_in = 8'h80, nz_en -> rd_data_a (sel 1) = 8'h80 next cycle, status 8'hA0; then gpr_dec on 8'h01 -> 8'h00, status 8'h22.
REQ-018 SP wrap: 256 consecutive sp_push cycles from 8'hFF -> SP back to 8'hFF, exactly one sp_wrap pulse (at the 8'h00 -> 8'hFF step); one sp_pop from 8'hFF -> 8'h00 with an sp_wrap pulse.
REQ-019 Simultaneous events: gpr_we with gpr_inc -> data_in wins; sp_push with sp_pop -> SP unchanged, no pulse; sp_load with sp_push -> loaded value.
REQ-020 Mask precedence: status_we, status_mask = 8'h02, data_status = 8'h00, together with nz_en increment to 8'h00 -> Z = 0 and N = 0 from the NZ update; other bits unchanged.
REQ-021 Parameter sweep: WIDTH = 16, NUM_GPR = 5 -> gpr_sel = 6 ignored, rd_sel = 7 reads 0, and 16'hFFFF + 1 = 0.
